// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Register-mapped controller for one uart_rx datapath core on the BeagleWire
// host bus. It owns the core's configuration, holds the core in reset while
// disabled, and defers configuration changes until the core is idle. Received
// words are buffered in a FIFO, with sticky error status and a level interrupt.
//
// Parameters:
//   FIFO_DEPTH        RX FIFO entries (2, 4, 8 or 16)
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   addr              register select: 0 CTRL, 1 CLKDIV, 2 STATUS, 3 DATA
//   wr_en, rd_en      one-cycle write / read strobes
//   wdata, rdata      write data / registered read data
//   irq               level interrupt
//   rx_rst            reset to the core
//   rx_clk_div, rx_bits_per_word, rx_parity_en, rx_parity_odd,
//   rx_two_stop_bit   active configuration driven to the core
//   rx_data, rx_new_data, rx_frame_error, rx_busy
//                     status and data from the core
//
// Build option:
//   UART_RX_CTRL_LEVEL_EN  when defined, STATUS[9:5] reports the FIFO level;
//                          otherwise those bits read 0.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        rx_rst,
  output logic [15:0] rx_clk_div,
  output logic [4:0]  rx_bits_per_word,
  output logic        rx_parity_en,
  output logic        rx_parity_odd,
  output logic        rx_two_stop_bit,
  input  logic [15:0] rx_data,
  input  logic        rx_new_data,
  input  logic        rx_frame_error,
  input  logic        rx_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CLKDIV = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_PEND  = 2'd3;

  // Sequencer
  logic [1:0]  state_q, state_d;

  // CTRL / CLKDIV shadow registers
  logic        enable_q, enable_d;
  logic        sh_parity_en_q, sh_parity_en_d;
  logic        sh_parity_odd_q, sh_parity_odd_d;
  logic        sh_two_stop_q, sh_two_stop_d;
  logic [4:0]  sh_bpw_q, sh_bpw_d;
  logic        irq_data_en_q, irq_data_en_d;
  logic        irq_err_en_q, irq_err_en_d;
  logic [15:0] sh_clk_div_q, sh_clk_div_d;

  // Active configuration seen by the core
  logic [15:0] act_clk_div_q, act_clk_div_d;
  logic [4:0]  act_bpw_q, act_bpw_d;
  logic        act_parity_en_q, act_parity_en_d;
  logic        act_parity_odd_q, act_parity_odd_d;
  logic        act_two_stop_q, act_two_stop_d;

  // Capture, status, FIFO, read port
  logic          new_data_q;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  // Decode
  logic        wr_ctrl, wr_clkdiv, wr_status, rd_data;
  logic        flush, cfg_change;
  logic        rise, capture_en, push_req, push, pop;
  logic        full, empty;
  logic [15:0] push_mask, push_data;
  logic [4:0]  level;
  logic [15:0] ctrl_word, status_word;

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_clkdiv = wr_en && (addr == ADDR_CLKDIV);
  assign wr_status = wr_en && (addr == ADDR_STATUS);
  assign rd_data   = rd_en && (addr == ADDR_DATA);
  assign flush     = wr_ctrl && wdata[15];

  // Only bits [8:1] of CTRL belong to the core; enable and irq masks never
  // force a re-apply.
  assign cfg_change = (wr_ctrl &&
                       (wdata[8:1] != {sh_bpw_q, sh_two_stop_q, sh_parity_odd_q, sh_parity_en_q}))
                    || wr_clkdiv;

  // ---------------------------------------------------------------------------
  // Host-visible control registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first so no path leaves it unassigned (which would infer a latch).
    enable_d        = enable_q;
    sh_parity_en_d  = sh_parity_en_q;
    sh_parity_odd_d = sh_parity_odd_q;
    sh_two_stop_d   = sh_two_stop_q;
    sh_bpw_d        = sh_bpw_q;
    irq_data_en_d   = irq_data_en_q;
    irq_err_en_d    = irq_err_en_q;
    sh_clk_div_d    = sh_clk_div_q;
    if (wr_ctrl) begin
      enable_d        = wdata[0];
      sh_parity_en_d  = wdata[1];
      sh_parity_odd_d = wdata[2];
      sh_two_stop_d   = wdata[3];
      sh_bpw_d        = wdata[8:4];
      irq_data_en_d   = wdata[9];
      irq_err_en_d    = wdata[10];
    end
    if (wr_clkdiv) begin
      sh_clk_div_d = wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer. Transitions look at the next enable value so that a CTRL write
  // moves the FSM on the very edge that captures it.
  // ---------------------------------------------------------------------------
  assign rise = rx_new_data && !new_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (enable_d) state_d = ST_APPLY;
      ST_APPLY: begin
        if (!enable_d)       state_d = ST_OFF;
        else if (cfg_change) state_d = ST_PEND;  // shadow moved after the copy
        else                 state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_d)       state_d = ST_OFF;
        else if (cfg_change) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!enable_d)               state_d = ST_OFF;
        else if (!rx_busy && !rise)  state_d = ST_APPLY;
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign rx_rst     = (state_q == ST_OFF) || (state_q == ST_APPLY);
  assign capture_en = (state_q == ST_RUN) || (state_q == ST_PEND);

  // Active configuration follows the shadow while the core is held in reset.
  always_comb begin
    act_clk_div_d    = act_clk_div_q;
    act_bpw_d        = act_bpw_q;
    act_parity_en_d  = act_parity_en_q;
    act_parity_odd_d = act_parity_odd_q;
    act_two_stop_d   = act_two_stop_q;
    if (rx_rst) begin
      act_clk_div_d    = sh_clk_div_q;
      act_bpw_d        = sh_bpw_q;
      act_parity_en_d  = sh_parity_en_q;
      act_parity_odd_d = sh_parity_odd_q;
      act_two_stop_d   = sh_two_stop_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and FIFO
  // ---------------------------------------------------------------------------
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = rd_data && !empty;
  assign push_req = rise && capture_en;
  // A pop in the same cycle frees the slot the push needs.
  assign push     = push_req && !flush && (!full || pop);

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      push_mask[i] = (5'(i) <= act_bpw_q);
    end
  end
  assign push_data = rx_data & push_mask;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Sticky errors: a new event in the clearing cycle wins over the clear.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_status && wdata[2]) overrun_d   = 1'b0;
    if (wr_status && wdata[3]) frame_err_d = 1'b0;
    if (push_req && !flush && full && !pop) overrun_d   = 1'b1;
    if (push_req && rx_frame_error)         frame_err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
`ifdef UART_RX_CTRL_LEVEL_EN
  assign level = 5'(count_q);
`else
  assign level = 5'd0;
`endif

  assign ctrl_word   = {5'd0, irq_err_en_q, irq_data_en_q, sh_bpw_q,
                        sh_two_stop_q, sh_parity_odd_q, sh_parity_en_q, enable_q};
  assign status_word = {6'd0, level, rx_busy, frame_err_q, overrun_q, full, empty};

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rdata_d = ctrl_word;
        ADDR_CLKDIV: rdata_d = sh_clk_div_q;
        ADDR_STATUS: rdata_d = status_word;
        default:     rdata_d = pop ? mem_q[rd_ptr_q] : 16'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (rst) begin
      state_q          <= ST_OFF;
      enable_q         <= 1'b0;
      sh_parity_en_q   <= 1'b0;
      sh_parity_odd_q  <= 1'b0;
      sh_two_stop_q    <= 1'b0;
      sh_bpw_q         <= '0;
      irq_data_en_q    <= 1'b0;
      irq_err_en_q     <= 1'b0;
      sh_clk_div_q     <= '0;
      act_clk_div_q    <= '0;
      act_bpw_q        <= '0;
      act_parity_en_q  <= 1'b0;
      act_parity_odd_q <= 1'b0;
      act_two_stop_q   <= 1'b0;
      new_data_q       <= 1'b0;
      overrun_q        <= 1'b0;
      frame_err_q      <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      enable_q         <= enable_d;
      sh_parity_en_q   <= sh_parity_en_d;
      sh_parity_odd_q  <= sh_parity_odd_d;
      sh_two_stop_q    <= sh_two_stop_d;
      sh_bpw_q         <= sh_bpw_d;
      irq_data_en_q    <= irq_data_en_d;
      irq_err_en_q     <= irq_err_en_d;
      sh_clk_div_q     <= sh_clk_div_d;
      act_clk_div_q    <= act_clk_div_d;
      act_bpw_q        <= act_bpw_d;
      act_parity_en_q  <= act_parity_en_d;
      act_parity_odd_q <= act_parity_odd_d;
      act_two_stop_q   <= act_two_stop_d;
      new_data_q       <= rx_new_data;
      overrun_q        <= overrun_d;
      frame_err_q      <= frame_err_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rdata_q          <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdata            = rdata_q;
  assign irq              = (irq_data_en_q && !empty) ||
                            (irq_err_en_q && (overrun_q || frame_err_q));
  assign rx_clk_div       = act_clk_div_q;
  assign rx_bits_per_word = act_bpw_q;
  assign rx_parity_en     = act_parity_en_q;
  assign rx_parity_odd    = act_parity_odd_q;
  assign rx_two_stop_bit  = act_two_stop_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed self-checking bench for uart_rx_ctrl (FIFO_DEPTH = 16). Inputs are
// driven on the falling edge and outputs sampled on the falling edge, half a
// cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;
  logic        rx_rst;
  logic [15:0] rx_clk_div;
  logic [4:0]  rx_bits_per_word;
  logic        rx_parity_en;
  logic        rx_parity_odd;
  logic        rx_two_stop_bit;
  logic [15:0] rx_data;
  logic        rx_new_data;
  logic        rx_frame_error;
  logic        rx_busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .wdata            (wdata),
    .rdata            (rdata),
    .irq              (irq),
    .rx_rst           (rx_rst),
    .rx_clk_div       (rx_clk_div),
    .rx_bits_per_word (rx_bits_per_word),
    .rx_parity_en     (rx_parity_en),
    .rx_parity_odd    (rx_parity_odd),
    .rx_two_stop_bit  (rx_two_stop_bit),
    .rx_data          (rx_data),
    .rx_new_data      (rx_new_data),
    .rx_frame_error   (rx_frame_error),
    .rx_busy          (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // STATUS[9:5] contribution for a given FIFO level.
  function automatic logic [15:0] lvl(input int n);
    logic [15:0] v;
    v = 16'(n) << 5;
`ifdef UART_RX_CTRL_LEVEL_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d     = rdata;
  endtask

  task automatic push(input logic [15:0] d, input logic fe);
    rx_data        = d;
    rx_frame_error = fe;
    rx_new_data    = 1'b1;
    @(negedge clk);
    rx_new_data    = 1'b0;
    rx_frame_error = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;

    rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    rx_data = '0; rx_new_data = 1'b0; rx_frame_error = 1'b0; rx_busy = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rx_rst", 16'(rx_rst), 16'd1);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_clk_div", rx_clk_div, 16'h0000);
    check("rst_bpw", 16'(rx_bits_per_word), 16'd0);
    check("rst_par", {13'd0, rx_parity_en, rx_parity_odd, rx_two_stop_bit}, 16'd0);
    rst = 1'b0;
    tick();
    rd(2'd2, d);
    check("rst_status", d, 16'h0001 | lvl(0));

    // Configure and receive
    wr(2'd1, 16'd4);
    wr(2'd0, 16'h0271);
    check("apply_rx_rst", 16'(rx_rst), 16'd1);
    tick();
    check("run_rx_rst", 16'(rx_rst), 16'd0);
    check("run_bpw", 16'(rx_bits_per_word), 16'd7);
    check("run_clk_div", rx_clk_div, 16'd4);
    rd(2'd0, d);
    check("ctrl_readback", d, 16'h0271);

    rx_data     = 16'h01A5;
    rx_new_data = 1'b1;            // held high: exactly one push expected
    repeat (4) tick();
    rx_new_data = 1'b0;
    tick();
    check("rx_irq_set", 16'(irq), 16'd1);
    rd(2'd2, d);
    check("rx_status_one", d, 16'h0000 | lvl(1));
    rd(2'd3, d);
    check("rx_data_masked", d, 16'h00A5);
    check("rx_irq_clear", 16'(irq), 16'd0);
    rd(2'd2, d);
    check("rx_status_empty", d, 16'h0001 | lvl(0));
    rd(2'd3, d);
    check("pop_empty_zero", d, 16'h0000);

    // Deferred apply
    rx_busy = 1'b1;
    wr(2'd1, 16'd8);
    check("pend_clk_div_old", rx_clk_div, 16'd4);
    check("pend_rx_rst", 16'(rx_rst), 16'd0);
    repeat (3) tick();
    check("pend_hold", rx_clk_div, 16'd4);
    rd(2'd2, d);
    check("pend_status_busy", d, 16'h0011 | lvl(0));
    rx_busy = 1'b0;
    tick();
    check("reapply_rx_rst", 16'(rx_rst), 16'd1);
    check("reapply_clk_div_old", rx_clk_div, 16'd4);
    tick();
    check("reapply_done_rst", 16'(rx_rst), 16'd0);
    check("reapply_clk_div", rx_clk_div, 16'd8);

    // Frame error with error irq only
    wr(2'd0, 16'h0471);
    push(16'h0155, 1'b1);
    check("fe_irq", 16'(irq), 16'd1);
    rd(2'd2, d);
    check("fe_status", d, 16'h0008 | lvl(1));
    rd(2'd3, d);
    check("fe_data", d, 16'h0055);
    check("fe_irq_sticky", 16'(irq), 16'd1);
    wr(2'd2, 16'h0008);
    check("fe_irq_cleared", 16'(irq), 16'd0);
    rd(2'd2, d);
    check("fe_status_cleared", d, 16'h0001 | lvl(0));

    // Overrun: 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) push(16'h0010 + 16'(i), 1'b0);
    rd(2'd2, d);
    check("ovr_status", d, 16'h0006 | lvl(16));
    check("ovr_irq", 16'(irq), 16'd1);
    for (int i = 1; i <= 16; i++) begin
      rd(2'd3, d);
      check($sformatf("ovr_pop%0d", i), d, 16'h0010 + 16'(i));
    end
    rd(2'd2, d);
    check("ovr_drained", d, 16'h0005 | lvl(0));
    wr(2'd2, 16'h0004);
    rd(2'd2, d);
    check("ovr_cleared", d, 16'h0001 | lvl(0));
    check("ovr_irq_clear", 16'(irq), 16'd0);

    // Full FIFO: push and pop in the same cycle
    for (int i = 1; i <= 16; i++) push(16'h0030 + 16'(i), 1'b0);
    rx_data     = 16'h00EE;
    rx_new_data = 1'b1;
    addr        = 2'd3;
    rd_en       = 1'b1;
    tick();
    rd_en       = 1'b0;
    rx_new_data = 1'b0;
    check("fullpp_oldest", rdata, 16'h0031);
    tick();
    rd(2'd2, d);
    check("fullpp_status", d, 16'h0002 | lvl(16));
    push(16'h0099, 1'b0);
    rd(2'd2, d);
    check("fullpp_overrun", d, 16'h0006 | lvl(16));

    // Flush keeps sticky bits
    wr(2'd0, 16'h8471);
    rd(2'd2, d);
    check("flush_status", d, 16'h0005 | lvl(0));
    rd(2'd0, d);
    check("flush_ctrl_reads0", d, 16'h0471);
    wr(2'd2, 16'h0004);

    // Disable mid-frame
    rx_busy = 1'b1;
    wr(2'd0, 16'h0470);
    check("dis_rx_rst", 16'(rx_rst), 16'd1);
    push(16'h0077, 1'b0);
    rd(2'd2, d);
    check("dis_no_push", d, 16'h0011 | lvl(0));
    rx_busy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
